// File: rtl/mmu_bridge_pkg.sv
// rtl/mmu_bridge_pkg.sv - shared defaults and FSM encoding for the MMU request bridge
package mmu_bridge_pkg;

  localparam int DEF_DATA_WIDTH        = 88;
  localparam int DEF_FIFO_DEPTH        = 4;
  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_FREE_PULSE_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_ACK  = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/mmu_req_fifo.sv
// rtl/mmu_req_fifo.sv - first-word-fall-through request buffer for the lookup pipeline
module mmu_req_fifo
  import mmu_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  output logic                          can_push,
  output logic                          valid,
  output logic [DATA_WIDTH-1:0]         data,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count_q;
  logic [DATA_WIDTH-1:0] last_q;
  logic                  pop;
  logic                  wr;

  assign valid    = (count_q != '0);
  assign pop      = valid && ready;
  // A full buffer still takes a write when the head leaves in the same cycle.
  assign can_push = (count_q != (AW+1)'(FIFO_DEPTH)) || pop;
  assign wr       = push && can_push;
  assign data     = valid ? mem[rd_ptr] : last_q;
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (valid) begin
        last_q <= mem[rd_ptr];
      end
      case ({wr, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmu_req_sync_bridge.sv
// rtl/mmu_req_sync_bridge.sv - click-request to clocked-domain bridge with free handshake
module mmu_req_sync_bridge
  import mmu_bridge_pkg::*;
#(
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int FREE_PULSE_CYCLES = DEF_FREE_PULSE_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_drive,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic                          o_free,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_data,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int CW = (FREE_PULSE_CYCLES > 1) ? $clog2(FREE_PULSE_CYCLES) : 1;

  (* dont_touch = "true", async_reg = "true" *) logic                   tog_q;
  (* dont_touch = "true", async_reg = "true" *) logic [SYNC_STAGES-1:0] sync_q;

  bridge_state_e         state_q;
  bridge_state_e         state_d;
  logic                  seen_tog;
  logic                  tog_s;
  logic                  req_event;
  logic                  latch_hold;
  logic                  fifo_push;
  logic                  fifo_can_push;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [CW-1:0]         free_cnt;

  // Each request edge flips the toggle, so pulses narrower than clk are never missed.
  always_ff @(posedge i_drive or posedge rst) begin
    if (rst) begin
      tog_q <= 1'b0;
    end else begin
      tog_q <= ~tog_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_q};
    end
  end

  assign tog_s     = sync_q[SYNC_STAGES-1];
  assign req_event = (tog_s != seen_tog);

  always_comb begin
    state_d    = state_q;
    latch_hold = 1'b0;
    fifo_push  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_event) begin
          latch_hold = 1'b1;
          state_d    = ST_PUSH;
        end
      end
      ST_PUSH: begin
        fifo_push = 1'b1;
        if (fifo_can_push) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (free_cnt == CW'(FREE_PULSE_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      seen_tog <= 1'b0;
      hold_q   <= '0;
      free_cnt <= '0;
      o_free   <= 1'b0;
    end else begin
      state_q  <= state_d;
      o_free   <= (state_d == ST_ACK);
      free_cnt <= (state_q == ST_ACK) ? free_cnt + 1'b1 : '0;
      if (latch_hold) begin
        hold_q   <= i_data;
        seen_tog <= tog_s;
      end
    end
  end

  mmu_req_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (hold_q),
    .can_push  (fifo_can_push),
    .valid     (o_valid),
    .data      (o_data),
    .ready     (i_ready),
    .count     (o_count)
  );

endmodule

// File: tb/tb_mmu_req_sync_bridge.sv
// tb/tb_mmu_req_sync_bridge.sv - self-checking bench for mmu_req_sync_bridge
module tb_mmu_req_sync_bridge;

  localparam int DW  = 88;
  localparam int FPC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_drive;
  logic [DW-1:0] i_data;
  logic          o_free;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          i_ready;
  logic [2:0]    o_count;

  int            checks = 0;
  int            errors = 0;
  int            popped = 0;
  int            free_len = 0;
  bit            rand_ready = 1'b0;
  logic [DW-1:0] exp_q[$];

  mmu_req_sync_bridge dut (
    .clk     (clk),
    .rst     (rst),
    .i_drive (i_drive),
    .i_data  (i_data),
    .o_free  (o_free),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Order model: every request sent must leave the head in send order, once.
  always @(negedge clk) begin
    if (rst) begin
      free_len = 0;
    end else begin
      chk("valid_vs_count", DW'(o_valid), DW'(o_count != 0));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_head: got %0h expected none", o_data);
        end else begin
          chk("head_data", o_data, exp_q[0]);
          if (i_ready) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      if (o_free) begin
        free_len++;
      end else if (free_len != 0) begin
        chk("free_width", DW'(free_len), DW'(FPC));
        free_len = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [DW-1:0] d);
    @(posedge clk);
    #2;
    i_data = d;
    exp_q.push_back(d);
    i_drive = 1'b1;
    #2;
    i_drive = 1'b0;
  endtask

  task automatic wait_free_high(input string name);
    int n = 0;
    while (o_free !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, DW'(o_free), DW'(1));
  endtask

  task automatic wait_free_done(input string name);
    int n = 0;
    wait_free_high(name);
    while (o_free !== 1'b0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_fall"}, DW'(o_free), DW'(0));
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (o_count !== 3'd0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, DW'(o_count), DW'(0));
  endtask

  initial begin
    int n;
    int hi;
    logic [95:0] r96;
    rst = 1'b1;
    i_drive = 1'b0;
    i_data = '0;
    i_ready = 1'b0;
    #3;
    chk("rst_count", DW'(o_count), DW'(0));
    chk("rst_valid", DW'(o_valid), DW'(0));
    chk("rst_free", DW'(o_free), DW'(0));
    chk("rst_data", o_data, DW'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Single request through an empty buffer with the sink ready.
    i_ready = 1'b1;
    send(88'hA5);
    n = 0;
    while (o_valid !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t1_valid", DW'(o_valid), DW'(1));
    chk("t1_data", o_data, 88'hA5);
    chk("t1_free_with_valid", DW'(o_free), DW'(1));
    @(posedge clk);
    #1;
    chk("t1_valid_one_cycle", DW'(o_valid), DW'(0));
    chk("t1_free_second", DW'(o_free), DW'(1));
    chk("t1_count", DW'(o_count), DW'(0));
    chk("t1_data_held", o_data, 88'hA5);
    @(posedge clk);
    #1;
    chk("t1_free_end", DW'(o_free), DW'(0));

    // Fill to four, fifth request is backpressured by a withheld free.
    @(posedge clk);
    #2;
    i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(DW'(i));
      wait_free_done("t2_free");
    end
    chk("t2_count_full", DW'(o_count), DW'(4));
    send(DW'(5));
    hi = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (o_free) hi++;
    end
    chk("t2_free_withheld", DW'(hi), DW'(0));
    chk("t2_count_still_full", DW'(o_count), DW'(4));
    chk("t2_head", o_data, DW'(1));
    // One-cycle ready: pop of entry 1 and write of entry 5 share the edge.
    @(posedge clk);
    #2;
    i_ready = 1'b1;
    @(posedge clk);
    #2;
    i_ready = 1'b0;
    chk("t3_count_same_cycle", DW'(o_count), DW'(4));
    chk("t3_free_after_pop", DW'(o_free), DW'(1));
    chk("t3_head_after_pop", o_data, DW'(2));
    wait_free_done("t3_free");
    @(posedge clk);
    #2;
    i_ready = 1'b1;
    wait_empty("t3_drain");
    chk("t3_popped", DW'(popped), DW'(6));

    // Second request arriving while the first is still being acknowledged.
    send(88'h1234_5678_9ABC);
    wait_free_high("t4_first_free");
    @(posedge clk);
    #2;
    i_data = 88'hDEAD_BEEF;
    exp_q.push_back(88'hDEAD_BEEF);
    i_drive = 1'b1;
    #2;
    i_drive = 1'b0;
    n = 0;
    while (o_free !== 1'b0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    wait_free_done("t4_second_free");
    wait_empty("t4_drain");
    chk("t4_popped", DW'(popped), DW'(8));

    // Reset during an acknowledge with three entries buffered.
    @(posedge clk);
    #2;
    i_ready = 1'b0;
    send(88'h11);
    wait_free_done("t5_free_a");
    send(88'h22);
    wait_free_done("t5_free_b");
    send(88'h33);
    wait_free_high("t5_free_c");
    chk("t5_count_pre", DW'(o_count), DW'(3));
    #1;
    rst = 1'b1;
    #1;
    chk("t5_free_abort", DW'(o_free), DW'(0));
    chk("t5_count_clear", DW'(o_count), DW'(0));
    chk("t5_valid_clear", DW'(o_valid), DW'(0));
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    i_ready = 1'b1;
    send(88'h44);
    wait_free_done("t5_after_rst");
    wait_empty("t5_drain");
    chk("t5_popped", DW'(popped), DW'(9));

    // Randomised traffic against a randomly stalling sink.
    rand_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      r96 = {$urandom(), $urandom(), $urandom()};
      repeat ($urandom_range(0, 5)) @(posedge clk);
      send(r96[DW-1:0]);
      wait_free_done("t6_free");
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    i_ready = 1'b1;
    wait_empty("t6_drain");
    repeat (3) @(posedge clk);
    #1;
    chk("t6_model_empty", DW'(exp_q.size()), DW'(0));
    chk("t6_total_popped", DW'(popped), DW'(1009));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
